// File: rtl/stopwatch_lap.sv
// stopwatch_lap: hh:mm:ss.cc stopwatch core driven by a divided clock tick.
// Adds a lap capture/hold display and an hour limit that either wraps to zero
// or saturates and stops. All outputs are registered.
module stopwatch_lap #(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned HOUR_MAX = 24,
    parameter bit          WRAP_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_runstop,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running,
    output logic       o_lap_hold,
    output logic       o_overflow
);

    localparam int unsigned      TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [4:0]       HourLast = 5'(HOUR_MAX - 1);

    localparam logic [1:0] StStop  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StClear = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;

    // Live time
    logic [6:0] cs_q, cs_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;

    // Lap snapshot
    logic [6:0] lap_cs_q, lap_cs_d;
    logic [5:0] lap_sec_q, lap_sec_d;
    logic [5:0] lap_min_q, lap_min_d;
    logic [4:0] lap_hour_q, lap_hour_d;
    logic       lap_hold_q, lap_hold_d;

    logic       ovf_q, ovf_d;

    // Registered output copies
    logic [6:0] msec_q;
    logic [5:0] osec_q;
    logic [5:0] omin_q;
    logic [4:0] ohour_q;
    logic       running_q;

    logic tick_hit;
    logic at_max;
    logic limit_hit;
    logic sat_stop;

    // Centisecond tick strobe and limit detection on the current live time.
    always_comb begin
        tick_hit  = (state_q == StRun) && (tick_q == TickLast);
        at_max    = (cs_q == 7'd99) && (sec_q == 6'd59) && (min_q == 6'd59) &&
                    (hour_q == HourLast);
        limit_hit = tick_hit && at_max;
        sat_stop  = limit_hit && !WRAP_EN;
    end

    // Run/stop/clear control.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StStop: begin
                // Clear wins over run/stop when both arrive together.
                if (i_clear) begin
                    state_d = StClear;
                end else if (i_runstop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (i_runstop || sat_stop) begin
                    state_d = StStop;
                end
            end
            StClear: state_d = StStop;
            default: state_d = StStop;
        endcase
    end

    // Tick divider: only advances while running, so a resume keeps its phase.
    always_comb begin
        tick_d = tick_q;
        if (state_q == StClear) begin
            tick_d = '0;
        end else if (state_q == StRun) begin
            if (tick_q == TickLast) begin
                tick_d = '0;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // Live time with cs -> sec -> min -> hour carry chain and hour limit handling.
    always_comb begin
        cs_d   = cs_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state_q == StClear) begin
            cs_d   = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick_hit) begin
            if (at_max) begin
                // Saturating mode simply keeps the maximum value.
                if (WRAP_EN) begin
                    cs_d   = '0;
                    sec_d  = '0;
                    min_d  = '0;
                    hour_d = '0;
                end
            end else if (cs_q != 7'd99) begin
                cs_d = cs_q + 7'd1;
            end else begin
                cs_d = '0;
                if (sec_q != 6'd59) begin
                    sec_d = sec_q + 6'd1;
                end else begin
                    sec_d = '0;
                    if (min_q != 6'd59) begin
                        min_d = min_q + 6'd1;
                    end else begin
                        min_d  = '0;
                        hour_d = hour_q + 5'd1;
                    end
                end
            end
        end
    end

    // Sticky overflow flag, dropped only by a clear.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StClear) begin
            ovf_d = 1'b0;
        end else if (limit_hit) begin
            ovf_d = 1'b1;
        end
    end

    // Lap capture/release. Capture takes the live value after this edge's increment.
    always_comb begin
        lap_cs_d   = lap_cs_q;
        lap_sec_d  = lap_sec_q;
        lap_min_d  = lap_min_q;
        lap_hour_d = lap_hour_q;
        lap_hold_d = lap_hold_q;
        if (state_q == StClear) begin
            lap_cs_d   = '0;
            lap_sec_d  = '0;
            lap_min_d  = '0;
            lap_hour_d = '0;
            lap_hold_d = 1'b0;
        end else if (i_lap) begin
            if (lap_hold_q) begin
                lap_hold_d = 1'b0;
            end else if (state_q == StRun) begin
                lap_cs_d   = cs_d;
                lap_sec_d  = sec_d;
                lap_min_d  = min_d;
                lap_hour_d = hour_d;
                lap_hold_d = 1'b1;
            end
        end
    end

    // Control and time state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StStop;
            tick_q  <= '0;
            cs_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cs_q    <= cs_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            ovf_q   <= ovf_d;
        end
    end

    // Lap snapshot registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_cs_q   <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            lap_hour_q <= '0;
            lap_hold_q <= 1'b0;
        end else begin
            lap_cs_q   <= lap_cs_d;
            lap_sec_q  <= lap_sec_d;
            lap_min_q  <= lap_min_d;
            lap_hour_q <= lap_hour_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    // Output registers: display mux fed from next-state values so the outputs
    // reflect the state established on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msec_q    <= '0;
            osec_q    <= '0;
            omin_q    <= '0;
            ohour_q   <= '0;
            running_q <= 1'b0;
        end else begin
            msec_q    <= lap_hold_d ? lap_cs_d   : cs_d;
            osec_q    <= lap_hold_d ? lap_sec_d  : sec_d;
            omin_q    <= lap_hold_d ? lap_min_d  : min_d;
            ohour_q   <= lap_hold_d ? lap_hour_d : hour_d;
            running_q <= (state_d == StRun);
        end
    end

    assign o_msec     = msec_q;
    assign o_sec      = osec_q;
    assign o_min      = omin_q;
    assign o_hour     = ohour_q;
    assign o_running  = running_q;
    assign o_lap_hold = lap_hold_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: drives a wrapping and a saturating stopwatch with the same
// pulses and checks both against a total-centisecond reference model.
module tb_stopwatch_lap;

    localparam int TickDiv = 4;
    localparam int HourMax = 2;
    localparam int MaxTot  = HourMax * 360000 - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_runstop = 1'b0;
    logic i_clear = 1'b0;
    logic i_lap = 1'b0;

    logic [6:0] msec_w, msec_s;
    logic [5:0] sec_w, sec_s, min_w, min_s;
    logic [4:0] hour_w, hour_s;
    logic       run_w, run_s, hold_w, hold_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    stopwatch_lap #(.TICK_DIV(TickDiv), .HOUR_MAX(HourMax), .WRAP_EN(1'b1)) dut_w (
        .clk(clk), .rst(rst), .i_runstop(i_runstop), .i_clear(i_clear), .i_lap(i_lap),
        .o_msec(msec_w), .o_sec(sec_w), .o_min(min_w), .o_hour(hour_w),
        .o_running(run_w), .o_lap_hold(hold_w), .o_overflow(ovf_w)
    );

    stopwatch_lap #(.TICK_DIV(TickDiv), .HOUR_MAX(HourMax), .WRAP_EN(1'b0)) dut_s (
        .clk(clk), .rst(rst), .i_runstop(i_runstop), .i_clear(i_clear), .i_lap(i_lap),
        .o_msec(msec_s), .o_sec(sec_s), .o_min(min_s), .o_hour(hour_s),
        .o_running(run_s), .o_lap_hold(hold_s), .o_overflow(ovf_s)
    );

    logic [26:0] got_w, got_s;
    assign got_w = {msec_w, sec_w, min_w, hour_w, run_w, hold_w, ovf_w};
    assign got_s = {msec_s, sec_s, min_s, hour_s, run_s, hold_s, ovf_s};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: index 0 wraps, index 1 saturates. State 0 stop, 1 run, 2 clear.
    int          m_st [2];
    int          m_ph [2];
    int          m_tot [2];
    int          m_lap [2];
    bit          m_hold [2];
    bit          m_ovf [2];
    logic [26:0] m_exp [2];

    typedef struct {
        bit rs;
        bit clr;
        bit lp;
        int w;
        int cs;
        bit run;
        bit hold;
        bit ovf;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [26:0] pack(input int d, input bit run, input bit hold,
                                         input bit ovf);
        return {7'(d % 100), 6'((d / 100) % 60), 6'((d / 6000) % 60), 5'(d / 360000),
                run, hold, ovf};
    endfunction

    task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_st[w] = 0; m_ph[w] = 0; m_tot[w] = 0; m_lap[w] = 0;
            m_hold[w] = 1'b0; m_ovf[w] = 1'b0; m_exp[w] = '0;
        end
    endtask

    task automatic model_step(input int w, input bit rs, input bit clr, input bit lp);
        bit inc;
        bit lim_stop;
        int st_n;
        int disp;
        if (m_st[w] == 2) begin
            m_st[w] = 0; m_ph[w] = 0; m_tot[w] = 0; m_lap[w] = 0;
            m_hold[w] = 1'b0; m_ovf[w] = 1'b0;
        end else begin
            inc = 1'b0;
            lim_stop = 1'b0;
            if (m_st[w] == 1) begin
                if (m_ph[w] == TickDiv - 1) begin
                    m_ph[w] = 0;
                    inc = 1'b1;
                end else begin
                    m_ph[w]++;
                end
            end
            if (inc) begin
                if (m_tot[w] == MaxTot) begin
                    m_ovf[w] = 1'b1;
                    if (w == 0) m_tot[w] = 0;
                    else lim_stop = 1'b1;
                end else begin
                    m_tot[w]++;
                end
            end
            if (lp) begin
                if (m_hold[w]) begin
                    m_hold[w] = 1'b0;
                end else if (m_st[w] == 1) begin
                    m_hold[w] = 1'b1;
                    m_lap[w] = m_tot[w];
                end
            end
            if (m_st[w] == 0) st_n = clr ? 2 : (rs ? 1 : 0);
            else st_n = (rs || lim_stop) ? 0 : 1;
            m_st[w] = st_n;
        end
        disp = m_hold[w] ? m_lap[w] : m_tot[w];
        m_exp[w] = pack(disp, m_st[w] == 1, m_hold[w], m_ovf[w]);
    endtask

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic cyc(input bit rs, input bit clr, input bit lp);
        i_runstop = rs;
        i_clear = clr;
        i_lap = lp;
        @(posedge clk);
        model_step(0, rs, clr, lp);
        model_step(1, rs, clr, lp);
        @(negedge clk);
        i_runstop = 1'b0;
        i_clear = 1'b0;
        i_lap = 1'b0;
        check("model_wrap", got_w, m_exp[0]);
        check("model_sat", got_s, m_exp[1]);
    endtask

    // Asynchronous reset between edges; outputs must drop without a clock.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("reset_wrap", got_w, 27'd0);
        check("reset_sat", got_s, 27'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Load live time in both DUTs while stopped; the held register value survives release.
    task automatic preload(input int v);
        force dut_w.cs_q   = 7'(v % 100);
        force dut_w.sec_q  = 6'((v / 100) % 60);
        force dut_w.min_q  = 6'((v / 6000) % 60);
        force dut_w.hour_q = 5'(v / 360000);
        force dut_s.cs_q   = 7'(v % 100);
        force dut_s.sec_q  = 6'((v / 100) % 60);
        force dut_s.min_q  = 6'((v / 6000) % 60);
        force dut_s.hour_q = 5'(v / 360000);
        m_tot[0] = v;
        m_tot[1] = v;
        cyc(1'b0, 1'b0, 1'b0);
        release dut_w.cs_q;
        release dut_w.sec_q;
        release dut_w.min_q;
        release dut_w.hour_q;
        release dut_s.cs_q;
        release dut_s.sec_q;
        release dut_s.min_q;
        release dut_s.hour_q;
    endtask

    task automatic add(input bit rs, input bit clr, input bit lp, input int w, input int cs,
                       input bit run, input bit hold, input bit ovf);
        vec_t v;
        v.rs = rs; v.clr = clr; v.lp = lp; v.w = w;
        v.cs = cs; v.run = run; v.hold = hold; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    initial begin
        // pulse rs/clr/lap, edges incl. pulse edge, displayed cs, running, hold, overflow
        add(1, 0, 0,   1,   0, 1, 0, 0);  // start
        add(0, 0, 0, 400, 100, 1, 0, 0);  // 100 ticks -> 1 s
        add(0, 0, 0,  42, 110, 1, 0, 0);  // 10 more ticks, phase 2
        add(1, 0, 0,   1, 110, 0, 0, 0);  // stop, phase 3
        add(0, 0, 0, 100, 110, 0, 0, 0);  // held while stopped
        add(1, 0, 0,   1, 110, 1, 0, 0);  // resume
        add(0, 0, 0,   1, 111, 1, 0, 0);  // kept phase ticks at once
        add(0, 0, 0,   4, 112, 1, 0, 0);
        add(0, 1, 0,   1, 112, 1, 0, 0);  // clear ignored in run
        add(1, 0, 0,   1, 112, 0, 0, 0);
        add(1, 1, 0,   1, 112, 0, 0, 0);  // clear wins, in CLEAR
        add(0, 0, 0,   1,   0, 0, 0, 0);  // zeroed
        add(1, 0, 0,   1,   0, 1, 0, 0);
        add(0, 0, 0,  20,   5, 1, 0, 0);
        add(0, 0, 1,   1,   5, 1, 1, 0);  // lap at 5
        add(0, 0, 0,  59,   5, 1, 1, 0);  // frozen while live reaches 20
        add(0, 0, 1,   1,  20, 1, 0, 0);  // release shows live
        add(0, 0, 1,   1,  20, 1, 1, 0);  // capture again
        add(1, 0, 1,   1,  20, 0, 0, 0);  // stop and release together
        add(0, 0, 1,   1,  20, 0, 0, 0);  // lap ignored when stopped

        model_reset();
        do_reset();

        foreach (tbl[i]) begin
            cyc(tbl[i].rs, tbl[i].clr, tbl[i].lp);
            repeat (tbl[i].w - 1) cyc(1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d", i), got_w,
                  pack(tbl[i].cs, tbl[i].run, tbl[i].hold, tbl[i].ovf));
        end

        // Hour limit: wrap vs saturate from 01:59:59.99
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        preload(MaxTot);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check("pre_limit", got_w, pack(MaxTot, 1'b1, 1'b0, 1'b0));
        cyc(1'b0, 1'b0, 1'b0);
        check("wrap_limit", got_w, pack(0, 1'b1, 1'b0, 1'b1));
        check("sat_limit", got_s, pack(MaxTot, 1'b0, 1'b0, 1'b1));
        cyc(1'b1, 1'b0, 1'b0);
        check("sat_rerun", got_s, pack(MaxTot, 1'b1, 1'b0, 1'b1));
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        check("sat_stays", got_s, pack(MaxTot, 1'b0, 1'b0, 1'b1));
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("sat_clear", got_s, pack(0, 1'b0, 1'b0, 1'b0));
        check("wrap_clear", got_w, pack(0, 1'b0, 1'b0, 1'b0));

        // Randomized pulses, some rounds started close to the hour limit
        for (int r = 0; r < 4; r++) begin
            do_reset();
            if (r != 0) preload(MaxTot - int'($urandom_range(0, 150)));
            cyc(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 2500; k++) begin
                cyc($urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0,
                    $urandom_range(0, 39) == 0);
            end
        end

        // Reset landing mid-run
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        repeat (37) cyc(1'b0, 1'b0, 1'b0);
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
